// File: rtl/app_mult_unsigned6x6_pkg.sv
// Shared definitions for the 6x6 unsigned shift-add multiplier: FSM encoding
// and default operand widths.
package app_mult_unsigned6x6_pkg;

    localparam int DEF_WIDTH1 = 6;
    localparam int DEF_WIDTH2 = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_WAIT = 2'd3
    } mult_state_t;

endpackage

// File: rtl/app_mult_unsigned6x6_shift_add_core.sv
// Iterative shift-add accumulator: one partial product (a gated by one bit of b,
// LSB first) is added per step; last flags the WIDTH2-th step.
module app_mult_shift_add_core
    import app_mult_unsigned6x6_pkg::*;
#(
    parameter int WIDTH1 = DEF_WIDTH1,
    parameter int WIDTH2 = DEF_WIDTH2,
    localparam int SW = WIDTH1 + WIDTH2,
    localparam int CW = $clog2(WIDTH2 + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [WIDTH1-1:0] a,
    input  logic [WIDTH2-1:0] b,
    output logic [SW-1:0]     acc,
    output logic              last
);

    logic [CW-1:0] cnt;

    // Selects bit idx of b_v and returns a_v weighted by 2^idx when that bit is set.
    function automatic logic [SW-1:0] partial_product(
        input logic [WIDTH1-1:0] a_v,
        input logic [WIDTH2-1:0] b_v,
        input logic [CW-1:0]     idx
    );
        logic [WIDTH2-1:0] b_sh;
        logic [SW-1:0]     a_ext;
        b_sh  = b_v >> idx;
        a_ext = SW'(a_v);
        return b_sh[0] ? (a_ext << idx) : '0;
    endfunction

    assign last = step && (cnt == CW'(WIDTH2 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc + partial_product(a, b, cnt);
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/app_mult_unsigned6x6.sv
// Unsigned A*B+cin multiplier built on an iterative shift-add core; the FSM
// captures operands on an en rising period and publishes sum once per period.
module app_mult_unsigned6x6
    import app_mult_unsigned6x6_pkg::*;
#(
    parameter int WIDTH1 = DEF_WIDTH1,
    parameter int WIDTH2 = DEF_WIDTH2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     en,
    input  logic [WIDTH1-1:0]        A,
    input  logic [WIDTH2-1:0]        B,
    input  logic                     cin,
    output logic [WIDTH1+WIDTH2-1:0] sum
);

    localparam int SW = WIDTH1 + WIDTH2;

    mult_state_t       state;
    logic [WIDTH1-1:0] a_cap;
    logic [WIDTH2-1:0] b_cap;
    logic              cin_cap;
    logic [SW-1:0]     acc;
    logic              last;
    logic              core_clear;
    logic              core_step;

    // The core is cleared on the capture edge and steps only while en stays high in RUN.
    assign core_clear = (state == ST_IDLE) && en;
    assign core_step  = (state == ST_RUN) && en;

    app_mult_shift_add_core #(
        .WIDTH1 (WIDTH1),
        .WIDTH2 (WIDTH2)
    ) u_core (
        .clk   (sys_clk),
        .rst   (sys_rst_n),
        .clear (core_clear),
        .step  (core_step),
        .a     (a_cap),
        .b     (b_cap),
        .acc   (acc),
        .last  (last)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state   <= ST_IDLE;
            sum     <= '0;
            a_cap   <= '0;
            b_cap   <= '0;
            cin_cap <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (en) begin
                        a_cap   <= A;
                        b_cap   <= B;
                        cin_cap <= cin;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Dropping en here abandons the result; sum keeps the old value.
                    if (!en) begin
                        state <= ST_IDLE;
                    end else begin
                        sum   <= acc + SW'(cin_cap);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_app_mult_unsigned6x6.sv
// Scoreboard bench for app_mult_unsigned6x6: stimulus queues (edge, value)
// expectations; a negedge monitor tracks the value sum must hold every cycle.
module tb_app_mult_unsigned6x6;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        en;
    logic [5:0]  A;
    logic [5:0]  B;
    logic        cin;
    logic [11:0] sum;

    typedef struct {
        int          due;
        logic [11:0] val;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_sum = '0;
    bit          end_flag = 1'b0;

    app_mult_unsigned6x6 dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sum       (sum)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Queue the value sum must take at a given edge.
    task automatic expect_at(input int due, input logic [11:0] val);
        exp_t e;
        e.due = due;
        e.val = val;
        sb.push_back(e);
    endtask

    // en high for 60 edges then low for one; operands are scrambled once RUN is under way.
    task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic c,
                          input logic [11:0] expv);
        int k;
        A   = a;
        B   = b;
        cin = c;
        en  = 1'b1;
        k   = cyc + 1;
        expect_at(k + 7, expv);
        repeat (3) @(posedge sys_clk);
        #1;
        A   = 6'($urandom);
        B   = 6'($urandom);
        cin = 1'($urandom);
        repeat (57) @(posedge sys_clk);
        #1;
        en = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int k;
        sys_rst_n = 1'b1;
        en        = 1'b0;
        A         = '0;
        B         = '0;
        cin       = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;

        run_op(6'd10, 6'd22, 1'b0, 12'd220);
        run_op(6'd31, 6'd48, 1'b0, 12'd1488);
        run_op(6'd45, 6'd19, 1'b0, 12'd855);
        run_op(6'd38, 6'd11, 1'b0, 12'd418);
        run_op(6'd49, 6'd51, 1'b0, 12'd2499);
        run_op(6'd46, 6'd53, 1'b0, 12'd2438);
        run_op(6'd63, 6'd63, 1'b1, 12'd3970);
        run_op(6'd0,  6'd0,  1'b1, 12'd1);

        // Abort: en drops at edge k+3, sum must stay at 1.
        A   = 6'd10;
        B   = 6'd22;
        cin = 1'b0;
        en  = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        en = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;

        // Reset at edge k+4 of a running computation.
        A   = 6'd45;
        B   = 6'd19;
        en  = 1'b1;
        k   = cyc + 1;
        repeat (4) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        en        = 1'b0;
        expect_at(k + 4, 12'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;

        run_op(6'd63, 6'd63, 1'b1, 12'd3970);
        repeat (5) @(posedge sys_clk);
        #1;
        end_flag = 1'b1;
    end

    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_sum = sb[0].val;
            void'(sb.pop_front());
        end
        checks++;
        if (sum !== exp_sum) begin
            errors++;
            $display("FAIL sum_check edge %0d: sum=%0d required %0d", cyc, sum, exp_sum);
        end
        if (end_flag) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
